// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI responder
// Purpose: FSM state encoding, SPI mode constants and a clog2 helper.
// Ports: none (package).
package spi_pkg;

  typedef enum logic [1:0] {
    WAIT_CS_HIGH = 2'd0,
    IDLE         = 2'd1,
    SHIFT        = 2'd2,
    DONE         = 2'd3
  } state_t;

  // Mode 0: SCK idles low, data sampled on the leading (rising) edge.
  localparam bit SPI_CPOL = 1'b0;
  localparam bit SPI_CPHA = 1'b0;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_responder_if.sv
// rtl/spi_responder_if.sv - SPI pin bundle between a master and a responder
// Purpose: groups the four SPI wires; master drives sck/cs/mosi, slave drives miso.
// Ports: none; modports master and slave.
interface spi_responder_if;

  logic spi_sck;
  logic spi_cs;
  logic spi_mosi;
  logic spi_miso;

  modport master (output spi_sck, output spi_cs, output spi_mosi, input spi_miso);
  modport slave  (input spi_sck, input spi_cs, input spi_mosi, output spi_miso);

endinterface

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - async input synchroniser with edge detect
// Purpose: SYNC_STAGES flop chain plus one delay flop; edges compare the last
//          stage against the delay flop.
// Ports: CLK50MHZ, RST (sync, active-high), async_i (raw pin),
//        level_o (synchronised level), rise_o / fall_o (one-cycle edge pulses).
module sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter bit RESET_VAL   = 1'b0
) (
  input  logic CLK50MHZ,
  input  logic RST,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      dly_q  <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = sync_q[SYNC_STAGES-1] & ~dly_q;
  assign fall_o  = ~sync_q[SYNC_STAGES-1] & dly_q;

endmodule

// File: rtl/spi_responder.sv
// rtl/spi_responder.sv - SPI mode-0 responder (slave) in the CLK50MHZ domain
// Purpose: oversamples SCK/CS/MOSI, receives a WIDTH-bit word MSB-first and
//          shifts out the reply word captured from data_in at frame start.
// Ports: CLK50MHZ, RST (sync, active-high); spi (slave modport: sck, cs, mosi in,
//        miso out, registered); data_in (reply word); data_out (last complete
//        word, held); rx_valid (one-cycle pulse on data_out update);
//        busy (frame in progress).
// Optional: define SPI_RESPONDER_FRAME_ERR_EN to add frame_err, pulsed on an
//           aborted frame or on an SCK rise after the word completed.
module spi_responder
  import spi_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK50MHZ,
  input  logic             RST,
  spi_responder_if.slave   spi,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             rx_valid,
  output logic             busy
`ifdef SPI_RESPONDER_FRAME_ERR_EN
  ,
  output logic             frame_err
`endif
);

  localparam int             BCW       = clog2(WIDTH) + 1;
  localparam logic [BCW-1:0] WIDTH_C   = BCW'(WIDTH);
  localparam logic [BCW-1:0] SETTLE_C  = BCW'(SYNC_STAGES);
  localparam bit             SAMPLE_ON_RISE = (SPI_CPOL == SPI_CPHA);

  logic sck_lvl, sck_rise, sck_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .CLK50MHZ(CLK50MHZ), .RST(RST), .async_i(spi.spi_sck),
    .level_o(sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .CLK50MHZ(CLK50MHZ), .RST(RST), .async_i(spi.spi_cs),
    .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .CLK50MHZ(CLK50MHZ), .RST(RST), .async_i(spi.spi_mosi),
    .level_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sck_lvl, mosi_rise, mosi_fall};

  logic sample_edge, shift_edge;
  assign sample_edge = SAMPLE_ON_RISE ? sck_rise : sck_fall;
  assign shift_edge  = SAMPLE_ON_RISE ? sck_fall : sck_rise;

  state_t           state_q, state_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             miso_q, miso_d;
  logic             rx_valid_q, rx_valid_d;
  logic             busy_q;
  logic             frame_err_d;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    data_out_d  = data_out_q;
    miso_d      = miso_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      WAIT_CS_HIGH: begin
        // The CS synchroniser resets to 1, so its level means nothing until the
        // chain has been refilled from the pin; bit_cnt counts those cycles.
        miso_d = 1'b0;
        if (bit_cnt_q < SETTLE_C) begin
          bit_cnt_d = bit_cnt_q + BCW'(1);
        end else if (cs_lvl) begin
          bit_cnt_d = '0;
          state_d   = IDLE;
        end
      end
      IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          tx_shift_d = data_in;
          miso_d     = data_in[WIDTH-1];
          bit_cnt_d  = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        // CS rise outranks any SCK edge in the same cycle.
        if (cs_rise) begin
          miso_d  = 1'b0;
          state_d = IDLE;
          if (bit_cnt_q == WIDTH_C) begin
            data_out_d = rx_shift_q;
            rx_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else if (bit_cnt_q == WIDTH_C) begin
          data_out_d = rx_shift_q;
          rx_valid_d = 1'b1;
          state_d    = DONE;
        end else if (sample_edge) begin
          rx_shift_d = {rx_shift_q[WIDTH-2:0], mosi_lvl};
          bit_cnt_d  = bit_cnt_q + BCW'(1);
        end else if (shift_edge) begin
          tx_shift_d = tx_shift_q << 1;
          miso_d     = tx_shift_q[WIDTH-2];
        end
      end
      DONE: begin
        if (cs_rise) begin
          miso_d  = 1'b0;
          state_d = IDLE;
        end else if (sample_edge) begin
          frame_err_d = 1'b1;
        end
      end
      default: state_d = WAIT_CS_HIGH;
    endcase
  end

  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      state_q    <= WAIT_CS_HIGH;
      bit_cnt_q  <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      data_out_q <= '0;
      miso_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      data_out_q <= data_out_d;
      miso_q     <= miso_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= (state_d == SHIFT) || (state_d == DONE);
    end
  end

  assign spi.spi_miso = miso_q;
  assign data_out     = data_out_q;
  assign rx_valid     = rx_valid_q;
  assign busy         = busy_q;

`ifdef SPI_RESPONDER_FRAME_ERR_EN
  logic frame_err_q;
  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
    end
  end
  assign frame_err = frame_err_q;
`else
  logic unused_frame_err;
  assign unused_frame_err = frame_err_d;
`endif

endmodule

// File: tb/tb_spi_responder.sv
// tb/tb_spi_responder.sv - scoreboard bench for spi_responder
module tb_spi_responder;

  localparam int WIDTH = 32;
  localparam int SYNC  = 2;
  localparam int HALF  = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] data_in = '0;
  logic [WIDTH-1:0] data_out;
  logic             rx_valid;
  logic             busy;
`ifdef SPI_RESPONDER_FRAME_ERR_EN
  logic             frame_err;
`endif

  always #10 clk = ~clk;

  spi_responder_if spi ();

  spi_responder #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
    .CLK50MHZ(clk),
    .RST(rst),
    .spi(spi),
    .data_in(data_in),
    .data_out(data_out),
    .rx_valid(rx_valid),
    .busy(busy)
`ifdef SPI_RESPONDER_FRAME_ERR_EN
    ,
    .frame_err(frame_err)
`endif
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int last_rise_cyc = 0;
  int exp_ferr    = 0;
  int seen_ferr   = 0;
  logic [WIDTH-1:0] exp_rx_q[$];
  logic [WIDTH-1:0] exp_miso_q[$];
  logic [WIDTH-1:0] last_rx = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Received-word monitor: each rx_valid pulse consumes one expected word.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_valid === 1'b1) begin
        if (exp_rx_q.size() == 0) begin
          check("rx_valid_unexpected", 32'd1, 32'd0);
        end else begin
          check("data_out", data_out, exp_rx_q.pop_front());
          check("rx_latency", cyc - last_rise_cyc, SYNC + 2);
        end
      end
`ifdef SPI_RESPONDER_FRAME_ERR_EN
      if (frame_err === 1'b1) seen_ferr++;
`endif
    end
  end

  // MISO monitor: collects bits at the pin on SCK rise while CS is low.
  initial begin
    logic [WIDTH-1:0] miso_word;
    int               miso_n;
    logic             prev_sck;
    logic             prev_cs;
    miso_word = '0;
    miso_n    = 0;
    prev_sck  = 1'b0;
    prev_cs   = 1'b1;
    forever begin
      @(spi.spi_sck or spi.spi_cs or rst);
      if (rst) begin
        miso_n = 0;
      end else if (prev_cs && !spi.spi_cs) begin
        miso_n    = 0;
        miso_word = '0;
      end else if (!prev_cs && spi.spi_cs) begin
        if (miso_n >= WIDTH) begin
          if (exp_miso_q.size() == 0) check("miso_unexpected", 32'd1, 32'd0);
          else check("miso_word", miso_word, exp_miso_q.pop_front());
        end
        miso_n = 0;
      end else if (!prev_sck && spi.spi_sck && !spi.spi_cs) begin
        if (miso_n < WIDTH) miso_word = {miso_word[WIDTH-2:0], spi.spi_miso};
        miso_n++;
      end
      prev_sck = spi.spi_sck;
      prev_cs  = spi.spi_cs;
    end
  end

  task automatic clock_bits(input logic [WIDTH-1:0] word, input int first, input int nbits);
    for (int i = first; i < first + nbits; i++) begin
      if (i < WIDTH) spi.spi_mosi = word[WIDTH-1-i];
      else spi.spi_mosi = 1'($urandom);
      repeat (HALF) @(negedge clk);
      spi.spi_sck = 1'b1;
      if (i == WIDTH - 1) last_rise_cyc = cyc;
      repeat (HALF) @(negedge clk);
      spi.spi_sck = 1'b0;
    end
  endtask

  task automatic cs_low();
    spi.spi_cs = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_high(input int gap);
    repeat (HALF) @(negedge clk);
    spi.spi_cs = 1'b1;
    repeat (gap) @(negedge clk);
    check("busy_after_cs_high", busy, 32'd0);
  endtask

  // Reference model: a frame of at least WIDTH bits yields its first WIDTH
  // MOSI bits on data_out and the reply word on MISO; shorter frames yield
  // nothing but one error; every rise past WIDTH is one overrun error.
  task automatic frame(input logic [WIDTH-1:0] word, input logic [WIDTH-1:0] reply,
                       input int nbits, input int gap);
    data_in = reply;
    if (nbits >= WIDTH) begin
      exp_rx_q.push_back(word);
      exp_miso_q.push_back(reply);
      last_rx  = word;
      exp_ferr = exp_ferr + (nbits - WIDTH);
    end else begin
      exp_ferr = exp_ferr + 1;
    end
    cs_low();
    check("busy_in_frame", busy, 32'd1);
    clock_bits(word, 0, nbits);
    cs_high(gap);
  endtask

  initial begin
    #3_000_000;
    vectors++;
    miscompares++;
    $display("FAIL watchdog: time %0t exceeded bound", $time);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    logic [WIDTH-1:0] w;
    spi.spi_sck  = 1'b0;
    spi.spi_cs   = 1'b1;
    spi.spi_mosi = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    check("reset_data_out", data_out, 32'd0);
    check("reset_rx_valid", rx_valid, 32'd0);
    check("reset_busy", busy, 32'd0);
    check("reset_miso", spi.spi_miso, 32'd0);
`ifdef SPI_RESPONDER_FRAME_ERR_EN
    check("reset_frame_err", frame_err, 32'd0);
`endif
    repeat (10) @(negedge clk);

    frame(32'hA5A5_0F0F, 32'h1234_5678, WIDTH, SYNC + 4);

    frame(32'h0000_0001, $urandom, WIDTH, SYNC + 1);
    frame(32'hFFFF_FFFF, $urandom, WIDTH, SYNC + 1);

    frame(32'hDEAD_BEEF, $urandom, 17, SYNC + 1);
    check("abort_data_out_held", data_out, last_rx);

    // Reset in the middle of a frame; CS stays low for the remaining bits.
    data_in = 32'h0BAD_F00D;
    cs_low();
    clock_bits(32'h1357_9BDF, 0, 12);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_rx = '0;
    check("midreset_data_out", data_out, 32'd0);
    check("midreset_busy", busy, 32'd0);
    clock_bits(32'h1357_9BDF, 12, 20);
    check("midreset_miso_low", spi.spi_miso, 32'd0);
    check("midreset_busy_after_bits", busy, 32'd0);
    cs_high(SYNC + 1);
    check("midreset_data_out_kept", data_out, last_rx);

    frame(32'hCAFE_BABE, $urandom, WIDTH, SYNC + 3);

    frame($urandom, $urandom, WIDTH + 1, SYNC + 2);

    // data_in changes mid-frame; the reply was already captured.
    w = $urandom;
    data_in = 32'h1;
    exp_rx_q.push_back(w);
    exp_miso_q.push_back(32'h1);
    last_rx = w;
    cs_low();
    clock_bits(w, 0, 10);
    data_in = 32'h2;
    clock_bits(w, 10, WIDTH - 10);
    cs_high(SYNC + 1);

    for (int k = 0; k < 16; k++) begin
      int sel;
      int n;
      sel = int'($urandom_range(0, 3));
      if (sel == 0) n = int'($urandom_range(1, WIDTH - 1));
      else if (sel == 3) n = int'($urandom_range(WIDTH + 1, WIDTH + 2));
      else n = WIDTH;
      frame($urandom, $urandom, n, int'($urandom_range(SYNC + 1, SYNC + 8)));
      check("data_out_hold", data_out, last_rx);
    end

    repeat (20) @(negedge clk);
    check("rx_queue_drained", exp_rx_q.size(), 32'd0);
    check("miso_queue_drained", exp_miso_q.size(), 32'd0);
`ifdef SPI_RESPONDER_FRAME_ERR_EN
    check("frame_err_count", seen_ferr, exp_ferr);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
